// File: rtl/in_port_ctrl.sv
// ============================================================================
// in_port_ctrl
// ----------------------------------------------------------------------------
// Input-port unit for the pipelined CPU wrapper. It is the inbound counterpart
// of the O_Port output path. An external producer pushes bytes into a small
// first-word-fall-through FIFO over a valid/ready handshake. The IN
// instruction pops one byte. While the FIFO is empty, an IN in EX stalls the
// pipeline.
//
// Parameters
//   DEPTH       FIFO entries (power of 2, >= 2)
//   DW          data width (CPU datapath width)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   ext_data    byte offered by the external producer
//   ext_valid   producer offers ext_data this cycle
//   ext_ready   FIFO can accept a byte (push = ext_valid & ext_ready)
//   in_rd       IN instruction in EX requests a byte
//   in_data     FIFO head; zero while the FIFO is empty
//   in_stall    in_rd while the FIFO is empty; the pipeline holds EX
//   fifo_level  current occupancy, 0..DEPTH
//   irq         data-available interrupt pulse
//
// Configuration
//   IN_PORT_IRQ_EN  When defined, irq is a registered one-cycle pulse on every
//                   empty -> non-empty transition. When undefined, irq is
//                   tied to 0 and the edge-detect flop does not exist.
// ============================================================================
module in_port_ctrl #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              ext_data,
    input  logic                       ext_valid,
    output logic                       ext_ready,
    input  logic                       in_rd,
    output logic [DW-1:0]              in_data,
    output logic                       in_stall,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             empty;
    logic             push;
    logic             pop;

    assign empty = (level == '0);

    // ext_ready depends only on the registered level. A pop in the same cycle
    // does not open a slot, so a full FIFO never pushes through.
    assign ext_ready = (level != LVL_W'(DEPTH));
    assign push      = ext_valid & ext_ready;
    assign pop       = in_rd & ~empty;

    // There is no bypass path. A byte pushed into an empty FIFO appears at the
    // head one cycle later, so the stall covers the push cycle too.
    assign in_stall   = in_rd & empty;
    assign in_data    = empty ? '0 : mem[rd_ptr];
    assign fifo_level = level;

    // Storage and pointers. The level counter is kept separately from the
    // pointers, so full and empty are told apart without an extra pointer bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= ext_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef IN_PORT_IRQ_EN
    logic irq_q;

    // A push while the FIFO is empty is exactly the empty -> non-empty edge.
    // No pop can happen while the FIFO is empty, so that push always raises
    // the level. The pulse is high during the first cycle the data is
    // available.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= push & empty;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_in_port_ctrl.sv
// ============================================================================
// tb_in_port_ctrl
// ----------------------------------------------------------------------------
// Scoreboard bench for in_port_ctrl. Each byte the stimulus expects to be
// accepted is queued. A monitor pops the queue whenever the CPU side
// completes an IN (in_rd high, no stall, not in reset) and compares the value
// against in_data. The stimulus thread also checks level, ready, stall and
// irq against hand-computed values after every applied cycle.
// ============================================================================
module tb_in_port_ctrl;

    localparam int DEPTH = 4;
    localparam int DW    = 8;

`ifdef IN_PORT_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic                    clk;
    logic                    rst;
    logic [DW-1:0]           ext_data;
    logic                    ext_valid;
    logic                    ext_ready;
    logic                    in_rd;
    logic [DW-1:0]           in_data;
    logic                    in_stall;
    logic [$clog2(DEPTH):0]  fifo_level;
    logic                    irq;

    int checks_total  = 0;
    int checks_passed = 0;
    logic [DW-1:0] expected_q [$];

    in_port_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ext_data   (ext_data),
        .ext_valid  (ext_valid),
        .ext_ready  (ext_ready),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .in_stall   (in_stall),
        .fifo_level (fifo_level),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge. They are held until the
    // next edge samples them. Outputs are stable 2 units later.
    task automatic applyStimulus(input logic r, input logic v, input logic [DW-1:0] d, input logic rd);
        @(posedge clk);
        #1;
        rst       = r;
        ext_valid = v;
        ext_data  = d;
        in_rd     = rd;
        #2;
    endtask

    task automatic checkOutput(input string name, input int lvl, input logic rdy,
                               input logic stall, input logic irq_pulse);
        check({name, ".level"},  int'(fifo_level), lvl);
        check({name, ".ready"},  int'(ext_ready),  int'(rdy));
        check({name, ".stall"},  int'(in_stall),   int'(stall));
        check({name, ".irq"},    int'(irq),        int'(irq_pulse & IRQ_EN));
    endtask

    // The monitor pops the queue on every completed IN. It samples on the
    // falling edge, well away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && in_rd && !in_stall) begin
                if (expected_q.size() == 0) begin
                    checks_total++;
                    $display("[TB] FAIL pop_unexpected: got 0x%0h, expected no pop at %0t", in_data, $time);
                end else begin
                    check("pop_data", int'(in_data), int'(expected_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        ext_valid = 1'b0;
        ext_data  = '0;
        in_rd     = 1'b0;

        // 1) Hold reset for two edges with the producer offering data.
        applyStimulus(1, 1, 8'hFF, 0);
        applyStimulus(1, 1, 8'hFF, 0);
        checkOutput("reset", 0, 1, 0, 0);
        check("reset.in_data", int'(in_data), 0);

        // 2) Push 0x55, then pop it.
        applyStimulus(0, 1, 8'h55, 0);
        expected_q.push_back(8'h55);
        checkOutput("t2_push", 0, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("t2_pop", 1, 1, 0, 1);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("t2_idle", 0, 1, 0, 0);

        // 3) Stall on empty for three cycles, then push 0xA3 while still stalled.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 8'h00, 1);
            checkOutput("t3_stall", 0, 1, 1, 0);
        end
        applyStimulus(0, 1, 8'hA3, 1);
        expected_q.push_back(8'hA3);
        checkOutput("t3_push_stall", 0, 1, 1, 0);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("t3_pop", 1, 1, 0, 1);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("t3_idle", 0, 1, 0, 0);

        // 4) Fill to DEPTH. A fifth push is refused even with a pop that cycle.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1, 8'(i), 0);
            expected_q.push_back(8'(i));
            checkOutput("t4_fill", i - 1, 1, 0, (i == 2));
        end
        applyStimulus(0, 1, 8'h05, 0);
        checkOutput("t4_full", 4, 0, 0, 0);
        applyStimulus(0, 1, 8'h05, 1);
        checkOutput("t4_full_pop", 4, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("t4_pop2", 3, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("t4_pop3", 2, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("t4_pop4", 1, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("t4_empty", 0, 1, 0, 0);

        // 5) Wrap: bring level to 2, then four push+pop cycles, then drain.
        applyStimulus(0, 1, 8'h10, 0);
        expected_q.push_back(8'h10);
        checkOutput("t5_push10", 0, 1, 0, 0);
        applyStimulus(0, 1, 8'h11, 0);
        expected_q.push_back(8'h11);
        checkOutput("t5_push11", 1, 1, 0, 1);
        for (int i = 2; i < 6; i++) begin
            applyStimulus(0, 1, 8'(8'h10 + i), 1);
            expected_q.push_back(8'(8'h10 + i));
            checkOutput("t5_pushpop", 2, 1, 0, 0);
        end
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("t5_drain1", 2, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("t5_drain2", 1, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("t5_empty", 0, 1, 0, 0);

        // 6) Reset mid-operation discards contents and ignores push/pop that cycle.
        applyStimulus(0, 1, 8'h99, 0);
        applyStimulus(0, 1, 8'h9A, 0);
        checkOutput("t6_pre", 1, 1, 0, 1);
        applyStimulus(1, 1, 8'h9B, 1);
        checkOutput("t6_in_rst", 2, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("t6_after", 0, 1, 0, 0);
        check("t6.in_data", int'(in_data), 0);
        applyStimulus(0, 1, 8'hC4, 0);
        expected_q.push_back(8'hC4);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("t6_pop", 1, 1, 0, 1);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("t6_end", 0, 1, 0, 0);

        @(posedge clk);
        #1;
        check("queue_drained", expected_q.size(), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
